// File: rtl/rr_arbiter8_onehot_if.sv
// Requester-side bus of the 8-way round-robin arbiter.
// Request and enable flow in. The registered grant (index, one-hot and valid) flows out.
interface rr_arbiter8_onehot_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    modport master (output en, req, input gnt, gnt_idx, gnt_valid);
    modport slave  (input en, req, output gnt, gnt_idx, gnt_valid);
endinterface

// File: rtl/rr_arbiter8_onehot.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant.
// It has an optional hold-time limit and one idle cycle between owners (break-before-make).
module rr_arbiter8_onehot #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_arbiter8_onehot_if.slave  bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam bit         HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST    = HOLD_LIMITED ? 8'(MAX_HOLD - 1) : 8'd0;

    logic [0:0] state;
    logic [2:0] ptr;
    logic [7:0] hold_cnt;
    logic [7:0] gnt_q;
    logic [2:0] gnt_idx_q;
    logic       gnt_valid_q;

    logic [2:0] winner;
    logic [2:0] cand;
    logic       found;
    logic       release_now;

    // Circular search from ptr. The first hit wins, so ptr holds the highest priority.
    always_comb begin
        winner = ptr;
        cand   = ptr;
        found  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cand = ptr + 3'(k);
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        release_now = !bus.req[gnt_idx_q] || (HOLD_LIMITED && (hold_cnt == HOLD_LAST));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            hold_cnt    <= 8'd0;
            gnt_q       <= 8'd0;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en && found) begin
                        state       <= GRANT;
                        gnt_idx_q   <= winner;
                        gnt_q       <= 8'd1 << winner;
                        gnt_valid_q <= 1'b1;
                        hold_cnt    <= 8'd0;
                    end
                end
                GRANT: begin
                    // On release, ptr moves past the owner so that an owner that timed out is not favoured.
                    if (release_now) begin
                        state       <= IDLE;
                        gnt_q       <= 8'd0;
                        gnt_valid_q <= 1'b0;
                        ptr         <= gnt_idx_q + 3'd1;
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
endmodule

// File: tb/tb_rr_arbiter8_onehot.sv
// Bench for rr_arbiter8_onehot with three instances (MAX_HOLD = 16, 4 and 0).
// It uses vector tables, hand-written corner sequences and random traffic against a reference model.
module tb_rr_arbiter8_onehot;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_arbiter8_onehot_if bus16();
    rr_arbiter8_onehot_if bus4();
    rr_arbiter8_onehot_if bus0();

    rr_arbiter8_onehot #(.MAX_HOLD(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    rr_arbiter8_onehot #(.MAX_HOLD(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
    rr_arbiter8_onehot #(.MAX_HOLD(0))  dut0  (.clk(clk), .rst(rst), .bus(bus0));

    logic [7:0] req_v [3];
    logic       en_v  [3];

    assign bus16.req = req_v[0];
    assign bus16.en  = en_v[0];
    assign bus4.req  = req_v[1];
    assign bus4.en   = en_v[1];
    assign bus0.req  = req_v[2];
    assign bus0.en   = en_v[2];

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: owner is -1 when nobody holds the grant.
    // held counts the cycles in which the grant has been visible.
    int hold_lim [3] = '{16, 4, 0};
    int m_owner  [3];
    int m_last   [3];
    int m_start  [3];
    int m_held   [3];

    typedef struct {
        logic [7:0] req;
        logic       en;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
    } vec_t;

    vec_t vecs [24];

    function automatic void model_reset(int d);
        m_owner[d] = -1;
        m_last[d]  = 0;
        m_start[d] = 0;
        m_held[d]  = 0;
    endfunction

    function automatic void model_step(int d);
        int c;
        if (m_owner[d] >= 0) begin
            if (!req_v[d][m_owner[d]] || (hold_lim[d] != 0 && m_held[d] >= hold_lim[d])) begin
                m_start[d] = (m_owner[d] + 1) % 8;
                m_owner[d] = -1;
            end else begin
                m_held[d]++;
            end
        end else if (en_v[d] && req_v[d] != 8'd0) begin
            for (int i = 0; i < 8; i++) begin
                c = (m_start[d] + i) % 8;
                if (req_v[d][c]) begin
                    m_owner[d] = c;
                    m_last[d]  = c;
                    m_held[d]  = 1;
                    break;
                end
            end
        end
    endfunction

    function automatic logic [11:0] model_expected(int d);
        logic [7:0] g;
        g = (m_owner[d] >= 0) ? (8'd1 << m_owner[d]) : 8'd0;
        return {g, 3'(m_last[d]), (m_owner[d] >= 0)};
    endfunction

    function automatic logic [11:0] actual(int d);
        case (d)
            0:       return {bus16.gnt, bus16.gnt_idx, bus16.gnt_valid};
            1:       return {bus4.gnt,  bus4.gnt_idx,  bus4.gnt_valid};
            default: return {bus0.gnt,  bus0.gnt_idx,  bus0.gnt_valid};
        endcase
    endfunction

    task automatic applyStimulus(int d, logic [7:0] req, logic en);
        req_v[d] = req;
        en_v[d]  = en;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (rst) model_reset(d);
            else     model_step(d);
        end
        #1;
    endtask

    task automatic checkOutput(string name, int d, logic [11:0] exp);
        logic [11:0] act;
        act = actual(d);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s dut%0d: got gnt=%h idx=%0d valid=%b, expected gnt=%h idx=%0d valid=%b",
                     name, d, act[11:4], act[3:1], act[0], exp[11:4], exp[3:1], exp[0]);
        end
    endtask

    task automatic checkExact(string name, int d, logic [7:0] g, logic [2:0] i, logic v);
        checkOutput(name, d, {g, i, v});
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            applyStimulus(d, 8'h00, 1'b0);
            model_reset(d);
        end

        tick();
        tick();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) checkExact("reset_state", d, 8'h00, 3'd0, 1'b0);

        // Single owner, fairness, enable gating, break-before-make and release-versus-request on MAX_HOLD=16.
        vecs[0]  = '{8'h20, 1'b1, 8'h20, 3'd5, 1'b1};
        vecs[1]  = '{8'h20, 1'b1, 8'h20, 3'd5, 1'b1};
        vecs[2]  = '{8'h20, 1'b1, 8'h20, 3'd5, 1'b1};
        vecs[3]  = '{8'h00, 1'b1, 8'h00, 3'd5, 1'b0};
        vecs[4]  = '{8'h04, 1'b1, 8'h04, 3'd2, 1'b1};
        vecs[5]  = '{8'h00, 1'b1, 8'h00, 3'd2, 1'b0};
        vecs[6]  = '{8'h06, 1'b1, 8'h02, 3'd1, 1'b1};
        vecs[7]  = '{8'h06, 1'b1, 8'h02, 3'd1, 1'b1};
        vecs[8]  = '{8'h04, 1'b1, 8'h00, 3'd1, 1'b0};
        vecs[9]  = '{8'h04, 1'b1, 8'h04, 3'd2, 1'b1};
        vecs[10] = '{8'h00, 1'b1, 8'h00, 3'd2, 1'b0};
        vecs[11] = '{8'h80, 1'b0, 8'h00, 3'd2, 1'b0};
        vecs[12] = '{8'h80, 1'b0, 8'h00, 3'd2, 1'b0};
        vecs[13] = '{8'h80, 1'b1, 8'h80, 3'd7, 1'b1};
        vecs[14] = '{8'h80, 1'b0, 8'h80, 3'd7, 1'b1};
        vecs[15] = '{8'h80, 1'b0, 8'h80, 3'd7, 1'b1};
        vecs[16] = '{8'h00, 1'b0, 8'h00, 3'd7, 1'b0};
        vecs[17] = '{8'h01, 1'b0, 8'h00, 3'd7, 1'b0};
        vecs[18] = '{8'h01, 1'b1, 8'h01, 3'd0, 1'b1};
        vecs[19] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
        vecs[20] = '{8'h01, 1'b1, 8'h01, 3'd0, 1'b1};
        vecs[21] = '{8'h02, 1'b1, 8'h00, 3'd0, 1'b0};
        vecs[22] = '{8'h02, 1'b1, 8'h02, 3'd1, 1'b1};
        vecs[23] = '{8'h03, 1'b1, 8'h02, 3'd1, 1'b1};
        for (int v = 0; v < 24; v++) begin
            applyStimulus(0, vecs[v].req, vecs[v].en);
            tick();
            checkExact($sformatf("vec%0d", v), 0, vecs[v].gnt, vecs[v].idx, vecs[v].valid);
        end

        // A persistent requester on MAX_HOLD=16 is cut after 16 cycles, then wins again after one gap.
        applyStimulus(0, 8'h00, 1'b1);
        tick();
        checkExact("hold16_release", 0, 8'h00, 3'd1, 1'b0);
        applyStimulus(0, 8'h08, 1'b1);
        for (int c = 0; c < 16; c++) begin
            tick();
            checkExact($sformatf("hold16_c%0d", c), 0, 8'h08, 3'd3, 1'b1);
        end
        tick();
        checkExact("hold16_timeout", 0, 8'h00, 3'd3, 1'b0);
        tick();
        checkExact("hold16_regrant", 0, 8'h08, 3'd3, 1'b1);
        applyStimulus(0, 8'h00, 1'b1);
        tick();

        // Timeout rotation on MAX_HOLD=4 with every requester active, including the wrap from 7 to 0.
        applyStimulus(1, 8'hFF, 1'b1);
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                checkExact($sformatf("rot_o%0d_c%0d", k, c), 1, 8'd1 << (k % 8), 3'(k % 8), 1'b1);
            end
            tick();
            checkExact($sformatf("rot_gap%0d", k), 1, 8'h00, 3'(k % 8), 1'b0);
        end
        applyStimulus(1, 8'h00, 1'b1);
        tick();

        // Unlimited hold: requester 4 keeps the grant for 300 cycles while requester 0 also asks.
        applyStimulus(2, 8'h10, 1'b1);
        tick();
        checkExact("unlim_first", 2, 8'h10, 3'd4, 1'b1);
        applyStimulus(2, 8'h11, 1'b1);
        for (int c = 0; c < 300; c++) begin
            tick();
            checkExact("unlim_hold", 2, 8'h10, 3'd4, 1'b1);
        end
        applyStimulus(2, 8'h01, 1'b1);
        tick();
        checkExact("unlim_gap", 2, 8'h00, 3'd4, 1'b0);
        tick();
        checkExact("unlim_next", 2, 8'h01, 3'd0, 1'b1);

        // An asynchronous reset during a grant clears the outputs before the next edge.
        for (int d = 0; d < 3; d++) applyStimulus(d, 8'hFF, 1'b1);
        tick();
        tick();
        #3 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) checkExact("async_reset", d, 8'h00, 3'd0, 1'b0);
        tick();
        #3 rst = 1'b0;
        for (int d = 0; d < 3; d++) applyStimulus(d, 8'h00, 1'b1);
        applyStimulus(0, 8'h01, 1'b1);
        tick();
        checkExact("post_reset_grant", 0, 8'h01, 3'd0, 1'b1);

        // Random sticky traffic on all three instances, checked against the model every cycle.
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < 3; d++) begin
                if ($urandom_range(3) == 0)
                    req_v[d] = ($urandom_range(1) == 0) ? (8'($urandom) & 8'($urandom)) : 8'($urandom);
                en_v[d] = ($urandom_range(7) != 0);
            end
            tick();
            for (int d = 0; d < 3; d++) checkOutput($sformatf("rand%0d", c), d, model_expected(d));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
